// File: rtl/riscv_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_lsu_ctrl
//  Purpose  : Load/store sequencing controller between the core data-memory
//             port and a variable-latency data memory. Formats requests
//             (byte enables, lane-replicated store data, word-aligned
//             address), waits for the memory ready handshake under a
//             watchdog, and extracts / sign-extends loaded data.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT       max BUSY cycles without mem_ready_i before abort (>= 2)
//  Ports
//    clk_i         clock, rising edge
//    rst_i         synchronous reset, active low
//    core_req_i    core requests a memory access
//    core_we_i     1 = store, 0 = load
//    core_size_i   funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
//    core_addr_i   byte address
//    core_wd_i     store data (rs2)
//    core_rd_o     formatted load result, valid in DONE
//    core_stall_o  hold PC / write-back while an access is in flight
//    mem_req_o     memory request (registered)
//    mem_we_o      memory write enable (registered)
//    mem_be_o      byte enables (registered)
//    mem_addr_o    word-aligned address (registered)
//    mem_wd_o      lane-replicated store data (registered)
//    mem_rd_i      memory read word
//    mem_ready_i   memory completes the current request this cycle
//    misaligned_o  one-cycle pulse: illegal/misaligned access rejected
//    bus_err_o     one-cycle pulse: watchdog abort
// ============================================================================
module riscv_lsu_ctrl #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  // Watchdog counter only has to reach TIMEOUT-1.
  localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  // funct3 access-size encodings
  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  // Size and byte offset of the access in flight, kept for load extraction
  // because mem_addr_o only carries the word address.
  logic [2:0]        lat_size;
  logic [1:0]        lat_off;

  logic              req_illegal;
  logic [3:0]        req_be;
  logic [31:0]       req_wd;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;

  // --------------------------------------------------------------------------
  // Request legality: unknown sizes, unsigned sizes on stores, and natural
  // alignment violations are all rejected without touching memory.
  // --------------------------------------------------------------------------
  always_comb begin
    req_illegal = 1'b0;
    case (core_size_i)
      SZ_B:    req_illegal = 1'b0;
      SZ_H:    req_illegal = core_addr_i[0];
      SZ_W:    req_illegal = (core_addr_i[1:0] != 2'b00);
      SZ_BU:   req_illegal = core_we_i;
      SZ_HU:   req_illegal = core_we_i | core_addr_i[0];
      default: req_illegal = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request formatting. Store data is replicated across all lanes so the
  // memory can simply honour the byte enables. Loads always read the whole
  // word; mem_wd_o is a don't-care for loads.
  // --------------------------------------------------------------------------
  always_comb begin
    req_be = 4'b1111;
    req_wd = core_wd_i;
    case (core_size_i)
      SZ_B, SZ_BU: begin
        req_be = 4'b0001 << core_addr_i[1:0];
        req_wd = {4{core_wd_i[7:0]}};
      end
      SZ_H, SZ_HU: begin
        req_be = core_addr_i[1] ? 4'b1100 : 4'b0011;
        req_wd = {2{core_wd_i[15:0]}};
      end
      default: begin
        req_be = 4'b1111;
        req_wd = core_wd_i;
      end
    endcase
    if (!core_we_i) begin
      req_be = 4'b1111;
    end
  end

  // --------------------------------------------------------------------------
  // Load extraction from the returned word using the latched offset/size.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_byte   = mem_rd_i[{lat_off, 3'b000} +: 8];
    rd_half   = lat_off[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    load_data = mem_rd_i;
    case (lat_size)
      SZ_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
      SZ_BU:   load_data = {24'h000000, rd_byte};
      SZ_H:    load_data = {{16{rd_half[15]}}, rd_half};
      SZ_HU:   load_data = {16'h0000, rd_half};
      default: load_data = mem_rd_i;
    endcase
  end

  // Stall covers the request cycle in IDLE and every BUSY cycle; DONE is
  // left unstalled so the core retires the access at the end of DONE.
  assign core_stall_o = ((state == ST_IDLE) && core_req_i) || (state == ST_BUSY);

  // --------------------------------------------------------------------------
  // Sequencer with registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      lat_size     <= '0;
      lat_off      <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_be_o     <= '0;
      mem_addr_o   <= '0;
      mem_wd_o     <= '0;
      core_rd_o    <= '0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      // Error flags are single-cycle pulses.
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (core_req_i) begin
            if (req_illegal) begin
              misaligned_o <= 1'b1;
              core_rd_o    <= '0;
              state        <= ST_DONE;
            end else begin
              mem_req_o  <= 1'b1;
              mem_we_o   <= core_we_i;
              mem_be_o   <= req_be;
              mem_addr_o <= {core_addr_i[31:2], 2'b00};
              mem_wd_o   <= req_wd;
              lat_size   <= core_size_i;
              lat_off    <= core_addr_i[1:0];
              cnt        <= '0;
              state      <= ST_BUSY;
            end
          end
        end

        ST_BUSY: begin
          // Request fields stay frozen; core inputs are ignored here.
          if (mem_ready_i) begin
            mem_req_o <= 1'b0;
            if (!mem_we_o) begin
              core_rd_o <= load_data;
            end
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            // TIMEOUT BUSY cycles have elapsed without a response.
            mem_req_o <= 1'b0;
            core_rd_o <= '0;
            bus_err_o <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/riscv_lsu_ctrl.md
Name: riscv_lsu_ctrl

Overview:
Load/store sequencing controller between the core's data-memory port and a variable-latency data memory. It formats requests, waits for memory with a ready handshake and a watchdog, and extracts and sign-extends loaded data. It drives the core stall while an access is in flight. It sits between riscv_core (its mem_* outputs, stall_i and mem_rd_i) and the data memory or bus.

Parameters:
TIMEOUT, 256, maximum BUSY cycles without mem_ready_i before the access is aborted (must be at least 2).

Ports:
clk_i  in  1  clock; all state changes on the rising edge
rst_i  in  1  reset, synchronous, active-low
core_req_i  in  1  core requests a memory access (decoder mem_req)
core_we_i  in  1  1 = store, 0 = load
core_size_i  in  3  RISC-V funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
core_addr_i  in  32  byte address (ALU result)
core_wd_i  in  32  store data (rs2)
core_rd_o  out  32  load result, formatted; valid in DONE
core_stall_o  out  1  hold the core's PC and write-back
mem_req_o  out  1  memory request, registered
mem_we_o  out  1  memory write enable, registered
mem_be_o  out  4  byte enables, registered
mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}, registered
mem_wd_o  out  32  lane-replicated store data, registered
mem_rd_i  in  32  memory read word
mem_ready_i  in  1  memory completes the current request this cycle
misaligned_o  out  1  one-cycle pulse: misaligned or illegal access rejected
bus_err_o  out  1  one-cycle pulse: watchdog abort

Behaviour:
- Reset (rst_i low at an edge):
  - state goes to IDLE; watchdog counter 0.
  - All registered outputs go to 0: mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o, core_rd_o, misaligned_o, bus_err_o.
  - Reset taken mid-access abandons the access; mem_req_o is 0 after that edge.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If core_req_i is high and the access is legal: latch mem_* outputs, set mem_req_o = 1, counter = 0, go to BUSY.
  - If core_req_i is high and the access is illegal: pulse misaligned_o, core_rd_o = 0, no memory request, go to DONE.
  - Illegal means any of: H/HU with addr[0] = 1; W with addr[1:0] != 0; size 3, 6 or 7; store with size 4 or 5.
- BUSY:
  - mem_req_o and all mem_* outputs held stable.
  - mem_ready_i high: mem_req_o = 0; core_rd_o = formatted mem_rd_i for loads, unchanged for stores; go to DONE.
  - mem_ready_i low: counter increments; when counter == TIMEOUT-1, mem_req_o = 0, core_rd_o = 0, pulse bus_err_o, go to DONE.
  - core_req_i is ignored in BUSY; an access in progress always completes or times out.
- DONE: lasts one cycle, then IDLE. A new request is sampled only in IDLE.
- core_stall_o (combinational) = (IDLE & core_req_i) | BUSY. It is 0 in DONE, so the core retires the access at the end of DONE.
- Latency: minimum 3 cycles per access (IDLE, BUSY with ready, DONE). The stall lasts 2 + (BUSY cycles − 1) cycles.
- Store formatting:
  - SB: be = 4'b0001 << addr[1:0]; wd = {4{wd[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wd = {2{wd[15:0]}}.
  - SW: be = 4'b1111; wd = wd.
- Loads: be = 4'b1111, mem_we_o = 0.
- Load extraction uses the latched addr[1:0] and size:
  - B selects byte addr[1:0], sign-extended; BU zero-extends it.
  - H selects half addr[1], sign-extended; HU zero-extends it.
  - W passes the word through.
- misaligned_o and bus_err_o are never high together.
- mem_ready_i outside BUSY is ignored.

Test Plan:
1. LW, addr 0x100, mem_ready_i on the 2nd BUSY cycle, mem_rd_i = 0xDEADBEEF → mem_addr_o = 0x100, be = 0xF, mem_we_o = 0; core_rd_o = 0xDEADBEEF in DONE; core_stall_o high for 3 cycles, then low.
2. LB at 0x103 and LBU at 0x103, mem_rd_i = 0x80FF0000 → core_rd_o = 0xFFFFFF80 and 0x00000080 respectively. LH at 0x102 → 0xFFFF80FF.
3. SH, addr 0x202, wd 0x1234ABCD, ready on the 1st BUSY cycle → mem_we_o = 1, be = 0xC, mem_addr_o = 0x200, mem_wd_o = 0xABCDABCD; SB at 0x201 → be = 0x2, mem_wd_o = 0xCDCDCDCD.
4. LW at 0x101, and separately SW with size 4 → misaligned_o pulses once, mem_req_o stays 0, core_rd_o = 0, core_stall_o low in the next cycle.
5. mem_ready_i held low → bus_err_o pulses after exactly TIMEOUT BUSY cycles, mem_req_o drops, core_rd_o = 0, back to IDLE.
6. rst_i low during BUSY → after that edge mem_req_o = 0 and core_stall_o = core_req_i (IDLE). A later mem_ready_i is ignored, and the next request is issued normally.
